// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - LCD panel timing generator with one-cycle-early pixel coordinates
//
// Runs horizontal/vertical counters over the full panel timing, hands the
// display stage the active-area coordinate one cycle ahead of its DE cycle,
// and drives the panel pins from the returned (registered) pixel data.
//
// Optional build macro: LCD_TEST_PATTERN_EN replaces pixel_data with eight
// vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black).
//
// Ports:
//   lcd_pclk     in   1   pixel clock
//   rst          in   1   asynchronous reset, active-high
//   pixel_data   in   24  RGB888 returned by the display stage, one cycle after its coordinate
//   pixel_xpos   out  11  requested active-area column (0 outside the request window)
//   pixel_ypos   out  11  requested active-area row (0 outside the request window)
//   h_disp       out  11  active pixels per line
//   v_disp       out  11  active lines per frame
//   lcd_de       out  1   data enable
//   lcd_hs       out  1   horizontal sync, active-low
//   lcd_vs       out  1   vertical sync, active-low
//   lcd_bl       out  1   backlight enable
//   lcd_rgb      out  24  panel pixel data, forced to 0 outside DE
//   frame_start  out  1   one-cycle pulse at the start of each frame
module lcd_timing_gen #(
  parameter int H_SYNC  = 128,
  parameter int H_BACK  = 88,
  parameter int H_DISP  = 800,
  parameter int H_FRONT = 40,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10
) (
  input  logic        lcd_pclk,
  input  logic        rst,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_bl,
  output logic [23:0] lcd_rgb,
  output logic        frame_start
);

  localparam logic [10:0] H_TOTAL   = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT);
  localparam logic [10:0] V_TOTAL   = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT);
  localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
  // The horizontal request window opens one cycle before the first DE cycle
  // so the display stage has a cycle to register the pixel.
  localparam logic [10:0] H_REQ_BEG = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] H_REQ_END = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0] V_REQ_BEG = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_REQ_END = 11'(V_SYNC + V_BACK + V_DISP);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_req;
  logic        v_req;
  logic        req;

  assign h_disp = 11'(H_DISP);
  assign v_disp = 11'(V_DISP);

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 11'd1) begin
      h_cnt <= '0;
      if (v_cnt == V_TOTAL - 11'd1) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 11'd1;
      end
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign h_req = (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);
  assign v_req = (v_cnt >= V_REQ_BEG) && (v_cnt < V_REQ_END);
  assign req   = h_req && v_req;

  // Coordinates hold at 0 through blanking; the display stage pre-reads on that.
  assign pixel_xpos = req ? (h_cnt - H_REQ_BEG) : 11'd0;
  assign pixel_ypos = req ? (v_cnt - V_REQ_BEG) : 11'd0;

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      lcd_de      <= 1'b0;
      lcd_hs      <= 1'b1;
      lcd_vs      <= 1'b1;
      frame_start <= 1'b0;
      lcd_bl      <= 1'b0;
    end else begin
      lcd_de      <= req;
      lcd_hs      <= (h_cnt >= H_SYNC_W);
      lcd_vs      <= (v_cnt >= V_SYNC_W);
      frame_start <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
      lcd_bl      <= 1'b1;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  localparam int          BAR_W_INT = (H_DISP / 8 > 0) ? (H_DISP / 8) : 1;
  localparam logic [10:0] BAR_W     = 11'(BAR_W_INT);

  logic [10:0] xpos_q;
  logic [10:0] bar_num;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;
  logic        unused_pixel_data;

  assign unused_pixel_data = ^pixel_data;

  // Registered copy of the coordinate lines up with lcd_de.
  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      xpos_q <= '0;
    end else begin
      xpos_q <= pixel_xpos;
    end
  end

  // Columns past 8 full bars (H_DISP not a multiple of 8) stay in the last bar.
  assign bar_num = xpos_q / BAR_W;
  assign bar_idx = (bar_num > 11'd7) ? 3'd7 : bar_num[2:0];

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  assign lcd_rgb = lcd_de ? bar_rgb : 24'h000000;
`else
  assign lcd_rgb = lcd_de ? pixel_data : 24'h000000;
`endif

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

LCD panel timing generator that sits directly upstream of the picture/Canny display stage. It runs horizontal and vertical counters and issues one-cycle-early pixel coordinates (`pixel_xpos`, `pixel_ypos`) plus the panel geometry (`h_disp`, `v_disp`). It takes back the registered `pixel_data` and drives the panel's RGB, DE, HS and VS pins, aligned so that each returned pixel lands in its own DE cycle.

## Interface

Parameters:
- `H_SYNC`, 128: HS pulse width, pclk cycles
- `H_BACK`, 88: horizontal back porch
- `H_DISP`, 800: active pixels per line
- `H_FRONT`, 40: horizontal front porch (`H_TOTAL` = 1056)
- `V_SYNC`, 2: VS pulse width, lines
- `V_BACK`, 33: vertical back porch
- `V_DISP`, 480: active lines
- `V_FRONT`, 10: vertical front porch (`V_TOTAL` = 525)

Ports:
- `lcd_pclk`  in  1  pixel clock; the only clock
- `rst`  in  1  asynchronous reset, active-high
- `pixel_data`  in  24  RGB888 from the display stage; registered there one cycle after the coordinate
- `pixel_xpos`  out  11  active-area column being requested
- `pixel_ypos`  out  11  active-area row being requested
- `h_disp`  out  11  constant `H_DISP`
- `v_disp`  out  11  constant `V_DISP`
- `lcd_de`  out  1  data enable
- `lcd_hs`  out  1  horizontal sync, active-low
- `lcd_vs`  out  1  vertical sync, active-low
- `lcd_bl`  out  1  backlight enable
- `lcd_rgb`  out  24  panel data
- `frame_start`  out  1  one-cycle pulse at the start of each frame

## Operation

- `h_cnt` is 11 bits and runs 0..`H_TOTAL`-1, then wraps to 0.
- `v_cnt` is 11 bits. It increments only on the cycle where `h_cnt` = `H_TOTAL`-1, and wraps to 0 after `V_TOTAL`-1.
- Request window `req` (combinational):
  - horizontal: `h_cnt` in [`H_SYNC`+`H_BACK`-1, `H_SYNC`+`H_BACK`+`H_DISP`-1)
  - vertical: `v_cnt` in [`V_SYNC`+`V_BACK`, `V_SYNC`+`V_BACK`+`V_DISP`)
- Coordinate outputs:
  - `pixel_xpos` = `req` ? `h_cnt`-(`H_SYNC`+`H_BACK`-1) : 0
  - `pixel_ypos` = `req` ? `v_cnt`-(`V_SYNC`+`V_BACK`) : 0
  - Both are combinational from the counters, and both read 0 throughout blanking. The display stage's pre-read logic depends on this.
- Registered one cycle after the counters:
  - `lcd_de` <= `req`
  - `lcd_hs` <= !(`h_cnt` < `H_SYNC`)
  - `lcd_vs` <= !(`v_cnt` < `V_SYNC`)
  - `frame_start` <= (`h_cnt`==0 && `v_cnt`==0)
- `lcd_rgb` = `lcd_de` ? `pixel_data` : 24'h000000 (combinational from registers). No pixel value ever reaches the pins outside DE.
- `lcd_bl` goes to 1 on the first clock edge after reset release and stays at 1.
- `h_disp` and `v_disp` are tied to the parameters; they carry no logic.
- Arithmetic: the window bounds are computed in 11 bits. Every default sum is below 2048.
- Parameter constraint: `H_SYNC`+`H_BACK` >= 1.

## Timing

- Reset values, applied while `rst`=1 and asynchronously:
  - `h_cnt`=0, `v_cnt`=0
  - `lcd_de`=0, `lcd_hs`=1, `lcd_vs`=1, `frame_start`=0, `lcd_bl`=0, `lcd_rgb`=0
  - `pixel_xpos`=0, `pixel_ypos`=0
- Reset asserted mid-frame: all outputs drop to their reset values immediately. Counting restarts at `h_cnt`=0 on the first edge after release. No partial line is resumed.
- Latency: coordinate to pixel is exactly 1 cycle. Coordinate X at cycle t produces `lcd_rgb`=`pixel_data` for X at t+1, with `lcd_de`=1.
- Line timing with defaults:
  - `pixel_xpos` counts 0..799 while `h_cnt` runs 215..1014.
  - `lcd_de` is high while `h_cnt` is 216..1015.
  - `lcd_hs` is low while `h_cnt` is 1..128 (delayed by one register stage).
- Frame timing with defaults:
  - DE lines are `v_cnt` 35..514.
  - `lcd_vs` is low for the 2 lines following `v_cnt`=0, shifted by one pclk.
  - Frame period is 554400 cycles.
- Wrap-around: `h_cnt` and `v_cnt` wrap on the same edge at the end of the frame. `frame_start` pulses on the next cycle.

## Configuration

- `LCD_TEST_PATTERN_EN`
  - Defined: `lcd_rgb` ignores `pixel_data` and shows 8 vertical colour bars, each `H_DISP`/8 columns wide. Bar order: white, yellow, cyan, green, magenta, red, blue, black. The bar index comes from a registered copy of `pixel_xpos`, so it stays aligned with DE. It is still 0 outside DE. All sync, DE and coordinate behaviour is unchanged.
  - Undefined: normal pass-through as described under Operation.

## Test plan

- Reset: hold `rst`=1 for 5 cycles. Expect `lcd_de`=0, `lcd_hs`=1, `lcd_vs`=1, `lcd_bl`=0, `lcd_rgb`=0. After release, `lcd_bl`=1 after the first edge.
- Line: count one full line. Expect exactly 128 cycles of `lcd_hs`=0, 800 cycles of `lcd_de`=1, and a line period of 1056 cycles.
- Alignment: model `pixel_data` as {`pixel_ypos`[7:0], `pixel_xpos`[10:0], 5'b0}, registered. Expect every DE cycle's `lcd_rgb` to match the model for the coordinate issued one cycle earlier, and the first DE pixel of line 0 to decode as x=0, y=0.
- Frame: run 2 frames. Expect 480 DE lines per frame, `frame_start` pulses exactly 554400 cycles apart, and `pixel_ypos`=0 with `pixel_xpos`=0 throughout blanking.
- Mid-line reset: assert `rst` during `h_cnt`=500 of line 100. Expect `lcd_de` to fall in the same cycle. After release, the first DE comes 216 cycles later, on line `v_cnt`=35 only.
- With `LCD_TEST_PATTERN_EN`:
  - DE column 0 shows 24'hFFFFFF.
  - Column 100 shows 24'hFFFF00.
  - Column 799 shows 24'h000000.
